fetch_ctrl: RTL

- Instruction-fetch sequencer in front of the synchronous-read instruction ROM. The ROM returns data one clock after the address is presented.
- Generates the ROM address and tracks the in-flight read. Buffers returned words with their PCs in a small FIFO.
- Presents a valid/ready instruction stream to decode, and handles PC redirects (branch/jump/trap) with flush of stale fetches.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_ctrl_if.sv | 44 ++++
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/fetch_ctrl.sv | 100 ++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int FETCH_ADDRESS_WIDTH = 32;
    localparam int FETCH_DATA_WIDTH    = 32;

    // Byte distance between consecutive instruction words.
    localparam int PC_INC = 4;

    // Default first fetch address after reset.
    localparam logic [FETCH_ADDRESS_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One buffered instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [FETCH_ADDRESS_WIDTH-1:0] pc;
        logic [FETCH_DATA_WIDTH-1:0]    inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// ROM, redirect and decode-side signals of the fetch sequencer.
// The master side is the fetch sequencer; the slave side is the environment.
interface fetch_ctrl_if
    import fetch_pkg::*;
#(
    parameter int ADDRESS_WIDTH = FETCH_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = FETCH_DATA_WIDTH
);

    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]    mem_dout;
    logic                     redirect_valid;
    logic [ADDRESS_WIDTH-1:0] redirect_pc;
    logic                     inst_ready;
    logic                     inst_valid;
    logic [DATA_WIDTH-1:0]    inst_data;
    logic [ADDRESS_WIDTH-1:0] inst_pc;
    logic                     fetch_misaligned;

    modport master (
        output mem_addr,
        input  mem_dout,
        input  redirect_valid,
        input  redirect_pc,
        input  inst_ready,
        output inst_valid,
        output inst_data,
        output inst_pc,
        output fetch_misaligned
    );

    modport slave (
        input  mem_addr,
        output mem_dout,
        output redirect_valid,
        output redirect_pc,
        output inst_ready,
        input  inst_valid,
        input  inst_data,
        input  inst_pc,
        input  fetch_misaligned
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, inst} entries with flush.
// When empty, the head output keeps showing the last entry that was at the
// head, so decode sees stable values while inst_valid is low.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  fetch_entry_t               wr_entry,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fetch_entry_t   mem [DEPTH];
    fetch_entry_t   hold;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = empty ? hold : mem[rd_ptr];

    // Pointer and occupancy update; flush empties the buffer at once.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Entry storage; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // Remember the current head so it stays visible once the buffer drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold <= '0;
        end else if (!empty) begin
            hold <= mem[rd_ptr];
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer in front of a one-cycle synchronous ROM.
// Issues addresses, tracks the single in-flight read, buffers returned words
// with their PCs and handles redirects by flushing stale fetches.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = FETCH_ADDRESS_WIDTH,
    parameter int                       DATA_WIDTH    = FETCH_DATA_WIDTH,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = DEFAULT_RESET_PC,
    parameter int                       FIFO_DEPTH    = 2
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.master bus
);

    localparam int CW = $clog2(FIFO_DEPTH+1);

    logic [ADDRESS_WIDTH-1:0] fetch_pc;
    logic [ADDRESS_WIDTH-1:0] inflight_pc;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic                     inflight;
    logic                     misaligned;
    logic                     misaligned_next;
    logic                     redirect;
    logic                     pop;
    logic                     push;
    logic                     issue;
    logic [CW:0]              occ;
    logic [CW-1:0]            count;
    logic                     full;
    logic                     empty;
    fetch_entry_t             push_entry;
    fetch_entry_t             head_entry;

    assign redirect = bus.redirect_valid;

    // Next fetch address, handshake qualifiers and the issue decision.
    // A redirect throws away the buffer and the in-flight read, so the
    // occupancy it competes against is zero.
    always_comb begin
        addr            = redirect ? bus.redirect_pc : fetch_pc;
        misaligned_next = redirect ? (bus.redirect_pc[1:0] != 2'b00) : misaligned;
        pop             = bus.inst_valid & bus.inst_ready & ~redirect;
        occ             = '0;
        if (!redirect) begin
            occ = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
        end
        issue = ~misaligned_next & (occ < (CW+1)'(FIFO_DEPTH));
        // Space was reserved at issue time; the full check is only a safety net.
        push  = inflight & ~redirect & (~full | pop);
    end

    assign bus.mem_addr         = rst ? RESET_PC : addr;
    assign bus.inst_valid       = ~empty;
    assign bus.inst_pc          = head_entry.pc;
    assign bus.inst_data        = head_entry.inst;
    assign bus.fetch_misaligned = misaligned;

    assign push_entry.pc   = inflight_pc;
    assign push_entry.inst = bus.mem_dout;

    // Control state: fetch PC, in-flight flag and sticky misalignment flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc   <= RESET_PC;
            inflight   <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            misaligned <= misaligned_next;
            inflight   <= issue;
            if (issue) begin
                fetch_pc <= addr + ADDRESS_WIDTH'(PC_INC);
            end
        end
    end

    // PC of the read currently in flight, paired with the ROM word next cycle.
    always_ff @(posedge clk) begin
        if (issue) begin
            inflight_pc <= addr;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .flush    (redirect),
        .wr_entry (push_entry),
        .head     (head_entry),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

endmodule
